// File: rtl/plotter_pkg.sv
// Shared types and screen constants for the point plotter.
package plotter_pkg;

  localparam int COORD_W = 10;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  // Write-side state: collecting points, or holding a complete frame for the swap
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // One stored point in screen coordinates; vld = 0 marks a clipped or empty slot
  typedef struct packed {
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic               vld;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/point_bank.sv
// NUM_PTS-entry point register file: one write port, single-cycle clear of
// every valid bit, and all entries exposed in parallel on a flat bus.
module point_bank
  import plotter_pkg::*;
#(
  parameter int NUM_PTS = 8,
  parameter int AW      = $clog2(NUM_PTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_we,
  input  logic [AW-1:0]              i_waddr,
  input  entry_t                     i_wdata,
  input  logic                       i_clr,
  output logic [NUM_PTS*ENTRY_W-1:0] o_flat
);

  for (genvar gi = 0; gi < NUM_PTS; gi++) begin : g_ent
    entry_t r_ent;

    // Per-entry storage; clear only drops the valid bit, coordinates are don't-care
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ent <= '0;
      end else if (i_clr) begin
        r_ent.vld <= 1'b0;
      end else if (i_we && (i_waddr == AW'(gi))) begin
        r_ent <= i_wdata;
      end
    end

    assign o_flat[gi*ENTRY_W +: ENTRY_W] = r_ent;
  end

endmodule

// File: rtl/point_plotter.sv
// Maps rotated points to screen space, double-buffers one model frame of
// points, and raises a registered per-pixel hit flag for a square dot at
// each point of the displayed bank.
module point_plotter
  import plotter_pkg::*;
#(
  parameter int NUM_PTS  = 8,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int H_RES    = plotter_pkg::H_RES,
  parameter int V_RES    = plotter_pkg::V_RES,
  parameter int MARK     = 1
) (
  input  logic                      clk_100MHz,
  input  logic                      rst_n,
  input  logic                      pt_valid,
  input  logic                      pt_last,
  input  logic signed [COORD_W-1:0] rot_x,
  input  logic signed [COORD_W-1:0] rot_y,
  output logic                      pt_ready,
  input  logic                      frame_start,
  input  logic                      pixel_tick,
  input  logic                      video_on,
  input  logic [COORD_W-1:0]        x_pix,
  input  logic [COORD_W-1:0]        y_pix,
  output logic                      pixel_on,
  output logic                      drop_err
);

  localparam int AW = $clog2(NUM_PTS);
  localparam logic signed [COORD_W:0] MARK_S = (COORD_W+1)'(MARK);

  state_t                     r_state;
  logic [AW-1:0]              r_wptr;
  logic                       r_front_sel;
  logic                       r_drop_err;
  logic                       r_pixel_on;

  logic                       w_accept;
  logic                       w_swap;
  logic signed [COORD_W:0]    w_sx;
  logic signed [COORD_W:0]    w_sy;
  logic                       w_in_range;
  entry_t                     w_wdata;
  logic [NUM_PTS*ENTRY_W-1:0] w_flat [2];
  logic [NUM_PTS*ENTRY_W-1:0] w_front_flat;
  logic [NUM_PTS-1:0]         w_hit;

  assign pt_ready = (r_state == FILL);
  assign w_accept = pt_valid && pt_ready;
  assign w_swap   = (r_state == FULL) && frame_start;

  // Centre the origin and flip Y; 11-bit signed so off-screen results stay detectable
  assign w_sx = $signed({rot_x[COORD_W-1], rot_x}) + $signed((COORD_W+1)'(X_CENTER));
  assign w_sy = $signed((COORD_W+1)'(Y_CENTER)) - $signed({rot_y[COORD_W-1], rot_y});

  assign w_in_range = (w_sx >= 0) && (w_sx <= $signed((COORD_W+1)'(H_RES-1))) &&
                      (w_sy >= 0) && (w_sy <= $signed((COORD_W+1)'(V_RES-1)));

  assign w_wdata.sx  = w_sx[COORD_W-1:0];
  assign w_wdata.sy  = w_sy[COORD_W-1:0];
  assign w_wdata.vld = w_in_range;

  // Bank gi is written while it is the fill bank, and cleared as it leaves the front
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    point_bank #(
      .NUM_PTS (NUM_PTS),
      .AW      (AW)
    ) u_bank (
      .clk     (clk_100MHz),
      .rst_n   (rst_n),
      .i_we    (w_accept && (r_front_sel != 1'(gi))),
      .i_waddr (r_wptr),
      .i_wdata (w_wdata),
      .i_clr   (w_swap && (r_front_sel == 1'(gi))),
      .o_flat  (w_flat[gi])
    );
  end

  assign w_front_flat = r_front_sel ? w_flat[1] : w_flat[0];

  // Parallel dot test against every front entry
  for (genvar gi = 0; gi < NUM_PTS; gi++) begin : g_hit
    entry_t                  w_e;
    logic signed [COORD_W:0] w_dx;
    logic signed [COORD_W:0] w_dy;

    assign w_e       = w_front_flat[gi*ENTRY_W +: ENTRY_W];
    assign w_dx      = $signed({1'b0, x_pix}) - $signed({1'b0, w_e.sx});
    assign w_dy      = $signed({1'b0, y_pix}) - $signed({1'b0, w_e.sy});
    assign w_hit[gi] = w_e.vld && (w_dx >= -MARK_S) && (w_dx <= MARK_S) &&
                       (w_dy >= -MARK_S) && (w_dy <= MARK_S);
  end

  // Write FSM: fill one frame, then park until frame_start swaps the banks
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_wptr      <= '0;
      r_front_sel <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_wptr <= r_wptr + 1'b1;
            if (pt_last || (r_wptr == AW'(NUM_PTS-1))) begin
              r_state <= FULL;
            end
          end
        end
        FULL: begin
          if (frame_start) begin
            r_front_sel <= ~r_front_sel;
            r_wptr      <= '0;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Sticky flag for a point offered while the bank was full
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_err <= 1'b0;
    end else if (pt_valid && !pt_ready) begin
      r_drop_err <= 1'b1;
    end
  end

  // Pixel hit flag, updated once per pixel tick and held in between
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_on <= 1'b0;
    end else if (pixel_tick) begin
      r_pixel_on <= video_on && (|w_hit);
    end
  end

  assign drop_err = r_drop_err;
  assign pixel_on = r_pixel_on;

endmodule

// File: tb/tb_point_plotter.sv
// Self-checking bench for point_plotter: pixel expectations go through a
// scoreboard queue and are compared one clock after each pixel tick.
module tb_point_plotter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pt_valid;
  logic              pt_last;
  logic signed [9:0] rot_x;
  logic signed [9:0] rot_y;
  logic              pt_ready;
  logic              frame_start;
  logic              pixel_tick;
  logic              video_on;
  logic [9:0]        x_pix;
  logic [9:0]        y_pix;
  logic              pixel_on;
  logic              drop_err;

  int    err_cnt = 0;
  int    chk_cnt = 0;
  logic  exp_q[$];
  string tag_q[$];
  logic  tick_seen = 1'b0;
  logic  mon_exp;
  string mon_tag;

  always #5 clk = ~clk;

  point_plotter #(
    .NUM_PTS  (8),
    .X_CENTER (320),
    .Y_CENTER (240),
    .H_RES    (640),
    .V_RES    (480),
    .MARK     (1)
  ) dut (
    .clk_100MHz  (clk),
    .rst_n       (rst_n),
    .pt_valid    (pt_valid),
    .pt_last     (pt_last),
    .rot_x       (rot_x),
    .rot_y       (rot_y),
    .pt_ready    (pt_ready),
    .frame_start (frame_start),
    .pixel_tick  (pixel_tick),
    .video_on    (video_on),
    .x_pix       (x_pix),
    .y_pix       (y_pix),
    .pixel_on    (pixel_on),
    .drop_err    (drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard side: a tick sampled on a posedge is judged on the next negedge
  always @(posedge clk) tick_seen <= pixel_tick;

  always @(negedge clk) begin
    if (tick_seen) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        chk(mon_tag, {31'd0, pixel_on}, {31'd0, mon_exp});
      end
    end
  end

  task automatic push_pt(input int x, input int y, input logic last, input logic fs);
    @(negedge clk);
    pt_valid    = 1'b1;
    pt_last     = last;
    rot_x       = 10'(x);
    rot_y       = 10'(y);
    frame_start = fs;
    $display("push rot=(%0d,%0d) last=%0d frame_start=%0d ready=%0d", x, y, last, fs, pt_ready);
    @(negedge clk);
    pt_valid    = 1'b0;
    pt_last     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    $display("frame_start pulse, ready=%0d", pt_ready);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic px(input int x, input int y, input logic von, input logic exp);
    @(negedge clk);
    x_pix      = 10'(x);
    y_pix      = 10'(y);
    video_on   = von;
    pixel_tick = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back($sformatf("px(%0d,%0d,von=%0d)", x, y, von));
  endtask

  task automatic px_end();
    @(negedge clk);
    pixel_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input int x, input int y, input logic von, input logic exp);
    px(x, y, von, exp);
    px_end();
    $display("probe (%0d,%0d) von=%0d expect=%0d", x, y, von, exp);
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; rot_x = '0; rot_y = '0;
    frame_start = 1'b0; pixel_tick = 1'b0; video_on = 1'b0; x_pix = '0; y_pix = '0;
    repeat (3) @(negedge clk);
    chk("rst_pixel_on", {31'd0, pixel_on}, 32'd0);
    chk("rst_pt_ready", {31'd0, pt_ready}, 32'd1);
    chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
    rst_n = 1'b1;

    // First frame: nothing stored, nothing drawn
    probe(320, 240, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      px(int'($urandom_range(639)), int'($urandom_range(479)), 1'b1, 1'b0);
    end
    px_end();

    // Single point at origin; invisible until the swap
    push_pt(0, 0, 1'b1, 1'b0);
    chk("full_after_last", {31'd0, pt_ready}, 32'd0);
    probe(320, 240, 1'b1, 1'b0);
    pulse_fs();
    chk("ready_after_swap", {31'd0, pt_ready}, 32'd1);
    probe(320, 240, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("pixel_on_hold", {31'd0, pixel_on}, 32'd1);
    probe(321, 239, 1'b1, 1'b1);
    probe(322, 240, 1'b1, 1'b0);
    probe(320, 240, 1'b0, 1'b0);
    probe(319, 241, 1'b1, 1'b1);
    probe(320, 242, 1'b1, 1'b0);

    // Two points, one at the bottom-left screen corner
    push_pt(100, 100, 1'b0, 1'b0);
    push_pt(-320, -239, 1'b1, 1'b0);
    pulse_fs();
    probe(420, 140, 1'b1, 1'b1);
    probe(421, 141, 1'b1, 1'b1);
    probe(422, 140, 1'b1, 1'b0);
    probe(0, 479, 1'b1, 1'b1);
    probe(1, 478, 1'b1, 1'b1);
    probe(2, 479, 1'b1, 1'b0);
    probe(320, 240, 1'b1, 1'b0);

    // Clipped point: grid scan finds no dot
    push_pt(-400, 0, 1'b1, 1'b0);
    pulse_fs();
    for (int y = 1; y < 480; y += 3) begin
      for (int x = 1; x < 640; x += 3) begin
        px(x, y, 1'b1, 1'b0);
      end
    end
    px_end();

    // Overflow: eight fill the bank, the ninth is dropped
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("drop_err_before", {31'd0, drop_err}, 32'd0);
      push_pt(i * 10, 0, 1'b0, 1'b0);
      if (i == 6) chk("ready_after_7", {31'd0, pt_ready}, 32'd1);
      if (i == 7) chk("ready_after_8", {31'd0, pt_ready}, 32'd0);
    end
    chk("drop_err_set", {31'd0, drop_err}, 32'd1);
    pulse_fs();
    chk("ready_after_ovf_swap", {31'd0, pt_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      px(320 + i * 10, 240, 1'b1, 1'b1);
    end
    px(400, 240, 1'b1, 1'b0);
    px(325, 240, 1'b1, 1'b0);
    px_end();
    chk("drop_err_sticky", {31'd0, drop_err}, 32'd1);

    // frame_start while filling is ignored; coincident with last accept it is missed
    push_pt(50, 50, 1'b0, 1'b0);
    pulse_fs();
    chk("fill_fs_ignored", {31'd0, pt_ready}, 32'd1);
    probe(320, 240, 1'b1, 1'b1);
    probe(370, 190, 1'b1, 1'b0);
    push_pt(-50, -50, 1'b1, 1'b1);
    chk("coincident_fs_full", {31'd0, pt_ready}, 32'd0);
    probe(370, 190, 1'b1, 1'b0);
    probe(320, 240, 1'b1, 1'b1);
    pulse_fs();
    probe(370, 190, 1'b1, 1'b1);
    probe(270, 290, 1'b1, 1'b1);
    probe(320, 240, 1'b1, 1'b0);

    // Reset mid-fill clears pixel_on at once and discards both banks
    push_pt(0, 0, 1'b0, 1'b0);
    probe(370, 190, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pixel_on", {31'd0, pixel_on}, 32'd0);
    chk("async_rst_ready", {31'd0, pt_ready}, 32'd1);
    chk("async_rst_drop_err", {31'd0, drop_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    probe(370, 190, 1'b1, 1'b0);
    probe(270, 290, 1'b1, 1'b0);
    pulse_fs();
    probe(320, 240, 1'b1, 1'b0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
